// File: rtl/palette_pkg.sv
// Shared definitions for the double-buffered palette RAM: FSM encoding and
// the legal video read latency range.
package palette_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    COPY = 1'b1
  } pal_state_e;

  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 2;

  function automatic bit rd_latency_ok(input int lat);
    return (lat >= RD_LAT_MIN) && (lat <= RD_LAT_MAX);
  endfunction

endpackage

// File: rtl/palette_bank.sv
// Register-array palette bank: one synchronous write port, two asynchronous
// read ports. Contents start at zero and are never cleared by reset.
module palette_bank #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr_a,
  output logic [DATA_W-1:0] rdata_a,
  input  logic [ADDR_W-1:0] raddr_b,
  output logic [DATA_W-1:0] rdata_b
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH] = '{default: '0};

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata_a = mem[raddr_a];
  assign rdata_b = mem[raddr_b];

endmodule

// File: rtl/ram_palette_dbuf.sv
// Double-buffered colour palette: CPU writes a shadow bank, video reads the
// active bank; commit swaps them and resyncs the new shadow from the active.
module ram_palette_dbuf
  import palette_pkg::*;
#(
  parameter int ADDR_W        = 4,
  parameter int DATA_W        = 8,
  parameter int DOUBLE_BUFFER = 1,
  parameter int RD_LATENCY    = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr_wr,
  input  logic [DATA_W-1:0] data_in,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] cpu_addr_rd,
  output logic [DATA_W-1:0] cpu_data_out,
  input  logic              commit,
  output logic              busy,
  input  logic              vid_valid_in,
  input  logic [ADDR_W-1:0] addr_rd,
  output logic              vid_valid_out,
  output logic [DATA_W-1:0] data_out
);

  localparam int                DEPTH    = 1 << ADDR_W;
  localparam logic [ADDR_W:0]   IDX_LAST = (ADDR_W + 1)'(DEPTH - 1);

  if (!rd_latency_ok(RD_LATENCY)) begin : g_bad_rd_latency
    $error("ram_palette_dbuf: RD_LATENCY must be 1 or 2");
  end

  pal_state_e        state, state_nxt;
  logic [ADDR_W:0]   idx, idx_nxt;
  logic              bank_sel, bank_sel_nxt;
  logic              pending, pending_nxt;
  logic              copy_we;
  logic              shadow_we;
  logic [ADDR_W-1:0] shadow_waddr;
  logic [DATA_W-1:0] shadow_wdata;
  logic [DATA_W-1:0] vid_rdata, cpu_rdata, copy_rdata;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= (DOUBLE_BUFFER != 0) ? COPY : IDLE;
      idx      <= '0;
      bank_sel <= 1'b0;
      pending  <= 1'b0;
    end else begin
      state    <= state_nxt;
      idx      <= idx_nxt;
      bank_sel <= bank_sel_nxt;
      pending  <= pending_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    idx_nxt      = idx;
    bank_sel_nxt = bank_sel;
    pending_nxt  = pending;
    wr_ready     = 1'b0;
    busy         = 1'b0;
    copy_we      = 1'b0;
    case (state)
      IDLE: begin
        wr_ready = 1'b1;
        if (commit && (DOUBLE_BUFFER != 0)) begin
          bank_sel_nxt = ~bank_sel;
          idx_nxt      = '0;
          state_nxt    = COPY;
        end
      end
      COPY: begin
        busy    = 1'b1;
        copy_we = 1'b1;
        idx_nxt = idx + 1'b1;
        if (commit) pending_nxt = 1'b1;
        // A commit queued during the copy (or arriving on its last cycle) swaps again
        if (idx == IDX_LAST) begin
          if (pending || commit) begin
            pending_nxt  = 1'b0;
            bank_sel_nxt = ~bank_sel;
            idx_nxt      = '0;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign shadow_we    = copy_we | (we & wr_ready);
  assign shadow_waddr = copy_we ? idx[ADDR_W-1:0] : addr_wr;
  assign shadow_wdata = copy_we ? copy_rdata : data_in;

  if (DOUBLE_BUFFER != 0) begin : g_dbuf
    logic [DATA_W-1:0] rd_a [2];
    logic [DATA_W-1:0] rd_b [2];
    for (genvar b = 0; b < 2; b++) begin : g_bank
      logic is_active;
      assign is_active = (bank_sel == 1'(b));
      // Port B of the active bank feeds the copy; of the shadow bank, CPU readback
      palette_bank #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_bank (
        .clk     (clk),
        .we      (shadow_we && !is_active),
        .waddr   (shadow_waddr),
        .wdata   (shadow_wdata),
        .raddr_a (addr_rd),
        .rdata_a (rd_a[b]),
        .raddr_b (is_active ? idx[ADDR_W-1:0] : cpu_addr_rd),
        .rdata_b (rd_b[b])
      );
    end
    assign vid_rdata  = rd_a[bank_sel];
    assign copy_rdata = rd_b[bank_sel];
    assign cpu_rdata  = rd_b[~bank_sel];
  end else begin : g_single
    palette_bank #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_bank (
      .clk     (clk),
      .we      (shadow_we),
      .waddr   (shadow_waddr),
      .wdata   (shadow_wdata),
      .raddr_a (addr_rd),
      .rdata_a (vid_rdata),
      .raddr_b (cpu_addr_rd),
      .rdata_b (cpu_rdata)
    );
    assign copy_rdata = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) cpu_data_out <= '0;
    else       cpu_data_out <= cpu_rdata;
  end

  // Stage p1: registered active-bank read
  logic              vld_p1;
  logic [DATA_W-1:0] data_p1;

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p1  <= 1'b0;
      data_p1 <= '0;
    end else begin
      vld_p1  <= vid_valid_in;
      data_p1 <= vid_rdata;
    end
  end

  if (RD_LATENCY == 2) begin : g_lat2
    // Stage p2: extra output register
    logic              vld_p2;
    logic [DATA_W-1:0] data_p2;
    always_ff @(posedge clk) begin
      if (reset) begin
        vld_p2  <= 1'b0;
        data_p2 <= '0;
      end else begin
        vld_p2  <= vld_p1;
        data_p2 <= data_p1;
      end
    end
    assign vid_valid_out = vld_p2;
    assign data_out      = data_p2;
  end else begin : g_lat1
    assign vid_valid_out = vld_p1;
    assign data_out      = data_p1;
  end

endmodule

// File: tb/tb_ram_palette_dbuf.sv
// Directed bench for ram_palette_dbuf: double-buffered latency-1 and
// latency-2 instances plus a single-bank instance, driven from shared inputs.
module tb_ram_palette_dbuf;

  logic       clk = 1'b0;
  logic       reset;
  logic       we;
  logic [3:0] addr_wr;
  logic [7:0] data_in;
  logic [3:0] cpu_addr_rd;
  logic       commit;
  logic       vid_valid_in;
  logic [3:0] addr_rd;

  logic       wr_ready, busy, vid_valid_out;
  logic [7:0] cpu_data_out, data_out;
  logic       wr_ready_l2, busy_l2, vid_valid_out_l2;
  logic [7:0] cpu_data_out_l2, data_out_l2;
  logic       wr_ready_sb, busy_sb, vid_valid_out_sb;
  logic [7:0] cpu_data_out_sb, data_out_sb;

  int n_cmp = 0;
  int n_mis = 0;

  always #5 clk = ~clk;

  ram_palette_dbuf #(.ADDR_W(4), .DATA_W(8), .DOUBLE_BUFFER(1), .RD_LATENCY(1)) dut (
    .clk(clk), .reset(reset), .we(we), .addr_wr(addr_wr), .data_in(data_in),
    .wr_ready(wr_ready), .cpu_addr_rd(cpu_addr_rd), .cpu_data_out(cpu_data_out),
    .commit(commit), .busy(busy), .vid_valid_in(vid_valid_in), .addr_rd(addr_rd),
    .vid_valid_out(vid_valid_out), .data_out(data_out)
  );

  ram_palette_dbuf #(.ADDR_W(4), .DATA_W(8), .DOUBLE_BUFFER(1), .RD_LATENCY(2)) dut_l2 (
    .clk(clk), .reset(reset), .we(we), .addr_wr(addr_wr), .data_in(data_in),
    .wr_ready(wr_ready_l2), .cpu_addr_rd(cpu_addr_rd), .cpu_data_out(cpu_data_out_l2),
    .commit(commit), .busy(busy_l2), .vid_valid_in(vid_valid_in), .addr_rd(addr_rd),
    .vid_valid_out(vid_valid_out_l2), .data_out(data_out_l2)
  );

  ram_palette_dbuf #(.ADDR_W(4), .DATA_W(8), .DOUBLE_BUFFER(0), .RD_LATENCY(1)) dut_sb (
    .clk(clk), .reset(reset), .we(we), .addr_wr(addr_wr), .data_in(data_in),
    .wr_ready(wr_ready_sb), .cpu_addr_rd(cpu_addr_rd), .cpu_data_out(cpu_data_out_sb),
    .commit(commit), .busy(busy_sb), .vid_valid_in(vid_valid_in), .addr_rd(addr_rd),
    .vid_valid_out(vid_valid_out_sb), .data_out(data_out_sb)
  );

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Counts samples with busy high, starting with the current one, bounded
  task automatic count_busy(output int n);
    n = 0;
    while (busy && n < 64) begin
      n++;
      cyc();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    reset = 1'b1; we = 1'b0; addr_wr = '0; data_in = '0; cpu_addr_rd = '0;
    commit = 1'b0; vid_valid_in = 1'b0; addr_rd = '0;
    repeat (3) cyc();

    check_val("rst_data_out", data_out, 8'h00);
    check_val("rst_cpu_data_out", cpu_data_out, 8'h00);
    check_val("rst_vid_valid_out", vid_valid_out, 1'b0);
    check_val("rst_busy", busy, 1'b1);
    check_val("rst_wr_ready", wr_ready, 1'b0);
    check_val("rst_bank_sel", dut.bank_sel, 1'b0);
    check_val("rst_sb_busy", busy_sb, 1'b0);
    check_val("rst_sb_wr_ready", wr_ready_sb, 1'b1);

    // Startup resync
    reset = 1'b0;
    count_busy(n);
    check_val("init_busy_cycles", n, 16);
    check_val("init_wr_ready", wr_ready, 1'b1);

    for (int i = 0; i < 16; i++) begin
      addr_rd = 4'(i);
      vid_valid_in = 1'b1;
      cyc();
      check_val($sformatf("init_vid_idx%0d", i), data_out, 8'h00);
    end
    check_val("init_vid_valid", vid_valid_out, 1'b1);

    // Shadow write, then commit
    we = 1'b1; addr_wr = 4'd3; data_in = 8'hA5; cpu_addr_rd = 4'd3; addr_rd = 4'd3;
    cyc();
    we = 1'b0;
    check_val("cpu_same_cycle_old", cpu_data_out, 8'h00);
    check_val("vid_before_commit_a", data_out, 8'h00);
    check_val("sb_vid_read_before_write", data_out_sb, 8'h00);
    cyc();
    check_val("cpu_readback_idx3", cpu_data_out, 8'hA5);
    check_val("vid_before_commit_b", data_out, 8'h00);
    check_val("sb_vid_idx3", data_out_sb, 8'hA5);

    commit = 1'b1;
    cyc();
    commit = 1'b0;
    check_val("vid_inflight_old_bank", data_out, 8'h00);
    check_val("busy_after_commit", busy, 1'b1);
    check_val("bank_sel_after_commit", dut.bank_sel, 1'b1);
    cyc();
    check_val("vid_new_bank_idx3", data_out, 8'hA5);
    count_busy(n);
    check_val("commit1_remaining_busy", n, 15);
    check_val("wr_ready_after_copy", wr_ready, 1'b1);
    check_val("cpu_idx3_after_copy", cpu_data_out, 8'hA5);

    // Write in the same cycle as commit lands in the new active palette
    we = 1'b1; addr_wr = 4'd7; data_in = 8'h3C; commit = 1'b1; addr_rd = 4'd7;
    cyc();
    we = 1'b0; commit = 1'b0;
    check_val("vid_idx7_old", data_out, 8'h00);
    cyc();
    check_val("vid_idx7_swapped", data_out, 8'h3C);
    count_busy(n);
    check_val("commit2_remaining_busy", n, 15);
    cpu_addr_rd = 4'd7; addr_rd = 4'd3;
    cyc();
    check_val("cpu_idx7_after_copy", cpu_data_out, 8'h3C);
    check_val("vid_idx3_retained", data_out, 8'hA5);

    // Commit queued during COPY; a write during COPY is dropped
    check_val("bank_sel_before_double", dut.bank_sel, 1'b0);
    commit = 1'b1;
    cyc();
    commit = 1'b0;
    n = 0;
    while (busy && n < 64) begin
      commit = (n == 5);
      we = (n == 2);
      addr_wr = 4'd5; data_in = 8'h77;
      if (n == 2) begin
        check_val("wr_ready_during_copy", wr_ready, 1'b0);
        check_val("sb_busy_during_copy", busy_sb, 1'b0);
      end
      n++;
      cyc();
    end
    commit = 1'b0; we = 1'b0;
    check_val("double_commit_busy", n, 32);
    check_val("bank_sel_after_double", dut.bank_sel, 1'b0);
    cpu_addr_rd = 4'd5; addr_rd = 4'd5;
    cyc();
    check_val("cpu_dropped_write", cpu_data_out, 8'h00);
    check_val("vid_dropped_write", data_out, 8'h00);
    check_val("sb_accepted_write", data_out_sb, 8'h77);

    // Latency-2 instance
    vid_valid_in = 1'b0; addr_rd = 4'd3;
    cyc();
    cyc();
    check_val("l2_valid_idle", vid_valid_out_l2, 1'b0);
    vid_valid_in = 1'b1;
    cyc();
    vid_valid_in = 1'b0;
    check_val("l1_valid_1clk", vid_valid_out, 1'b1);
    check_val("l1_data_1clk", data_out, 8'hA5);
    check_val("l2_valid_1clk", vid_valid_out_l2, 1'b0);
    cyc();
    check_val("l2_valid_2clk", vid_valid_out_l2, 1'b1);
    check_val("l2_data_2clk", data_out_l2, 8'hA5);
    check_val("l1_valid_2clk", vid_valid_out, 1'b0);
    cyc();
    check_val("l2_valid_3clk", vid_valid_out_l2, 1'b0);

    // Single bank: writes are visible to video without commit
    we = 1'b1; addr_wr = 4'd1; data_in = 8'hFF; addr_rd = 4'd1;
    cyc();
    we = 1'b0;
    check_val("sb_idx1_write_edge", data_out_sb, 8'h00);
    cyc();
    check_val("sb_idx1_next_clk", data_out_sb, 8'hFF);
    check_val("sb_busy_end", busy_sb, 1'b0);
    check_val("sb_wr_ready_end", wr_ready_sb, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
